// File: rtl/ext_pipe.sv
// Immediate-extension unit for decode: computes zero/sign/upper/branch-offset extension
// and branch target, then holds results in a 2-entry valid/ready FIFO.
module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [2:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_pc4,
  output logic              out_err
);

  localparam int EXT_W = DATA_W - IMM_W;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    logic signed [DATA_W-1:0] s;
    s = {{EXT_W{imm[IMM_W-1]}}, imm};
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] ext_result(
    input logic [IMM_W-1:0]  imm,
    input logic [DATA_W-1:0] pc4,
    input logic [2:0]        mode
  );
    logic signed [DATA_W-1:0] s;
    logic signed [DATA_W-1:0] s_sh;
    logic [DATA_W-1:0]        r;
    s    = sext_imm(imm);
    s_sh = s <<< 2;
    case (mode)
      3'd0:    r = {{EXT_W{1'b0}}, imm};
      3'd1:    r = s;
      3'd2:    r = {imm, {EXT_W{1'b0}}};
      3'd3:    r = s_sh;
      3'd4:    r = pc4 + s_sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] ext_data_p0;
  logic              ext_err_p0;
  logic              push;
  logic              pop;

  logic [1:0]        count;
  logic              head;
  logic              tail;

  logic [DATA_W-1:0] data_mem [2];
  logic [DATA_W-1:0] pc_mem   [2];
  logic              err_mem  [2];

  // Stage p0: extension computed combinationally at push time
  always_comb begin
    ext_data_p0 = ext_result(in_imm, in_pc4, in_mode);
    ext_err_p0  = (in_mode > 3'd4);
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else if (flush) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Stage p1: storage, written only on an accepted push so contents hold under backpressure
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_mem[tail] <= ext_data_p0;
      pc_mem[tail]   <= in_pc4;
      err_mem[tail]  <= ext_err_p0;
    end
  end

  assign out_data = out_valid ? data_mem[head] : '0;
  assign out_pc4  = out_valid ? pc_mem[head]   : '0;
  assign out_err  = out_valid ? err_mem[head]  : 1'b0;

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: vector table, directed buffer corner cases, and random traffic
// against a queue-based reference model.
module tb_ext_pipe;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  in_imm;
  logic [DATA_W-1:0] in_pc4;
  logic [2:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_pc4;
  logic              out_err;

  ext_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_pc4(in_pc4), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_pc4(out_pc4), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] imm;
    logic [31:0] pc4;
    logic [2:0]  mode;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc4;
    logic        err;
  } ent_t;

  vec_t vecs [12];
  ent_t q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [31:0] pc4,
                       input logic [2:0] mode, input logic rdy, input logic fl);
    in_valid  = v;
    in_imm    = imm;
    in_pc4    = pc4;
    in_mode   = mode;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Reference: two's complement arithmetic on wide integers, truncated to 32 bits
  function automatic ent_t ref_ext(input logic [15:0] imm, input logic [31:0] pc4,
                                   input logic [2:0] mode);
    longint s;
    longint d;
    ent_t   e;
    s = longint'(imm);
    if (imm >= 16'h8000) s = s - 65536;
    d = 0;
    case (mode)
      3'd0: d = longint'(imm);
      3'd1: d = s;
      3'd2: d = longint'(imm) * 65536;
      3'd3: d = s * 4;
      3'd4: d = longint'(pc4) + s * 4;
      default: d = 0;
    endcase
    e.data = d[31:0];
    e.pc4  = pc4;
    e.err  = (mode >= 3'd5);
    return e;
  endfunction

  initial begin
    ent_t exp_e;
    logic m_push;
    logic m_pop;
    logic m_flush;

    vecs[0]  = '{16'h8001, 32'h0000_0010, 3'd1, 32'hFFFF_8001, 1'b0};
    vecs[1]  = '{16'h8001, 32'h0000_0020, 3'd0, 32'h0000_8001, 1'b0};
    vecs[2]  = '{16'h8001, 32'h0000_0030, 3'd2, 32'h8001_0000, 1'b0};
    vecs[3]  = '{16'hFFFF, 32'h0000_1000, 3'd4, 32'h0000_0FFC, 1'b0};
    vecs[4]  = '{16'h0001, 32'hFFFF_FFFC, 3'd4, 32'h0000_0000, 1'b0};
    vecs[5]  = '{16'h1234, 32'h0000_0040, 3'd6, 32'h0000_0000, 1'b1};
    vecs[6]  = '{16'h8000, 32'h0000_0050, 3'd3, 32'hFFFE_0000, 1'b0};
    vecs[7]  = '{16'h7FFF, 32'h0000_0060, 3'd3, 32'h0001_FFFC, 1'b0};
    vecs[8]  = '{16'h7FFF, 32'h0000_0070, 3'd1, 32'h0000_7FFF, 1'b0};
    vecs[9]  = '{16'h1234, 32'h0000_0080, 3'd5, 32'h0000_0000, 1'b1};
    vecs[10] = '{16'hABCD, 32'h0000_0090, 3'd7, 32'h0000_0000, 1'b1};
    vecs[11] = '{16'h0004, 32'h0000_0100, 3'd4, 32'h0000_0110, 1'b0};

    rstn = 1'b0;
    drive(1'b0, 16'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_pc4", out_pc4, 0);
    chk("reset_out_err", out_err, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Vector table: push one entry into the empty buffer, expect it one cycle later
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].imm, vecs[i].pc4, vecs[i].mode, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0, 32'h0, 3'd0, 1'b1, 1'b0);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_pc4", i), out_pc4, vecs[i].pc4);
      chk($sformatf("vec%0d_err", i), out_err, vecs[i].exp_err);
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("vec%0d_drained", i), out_valid, 0);
    end

    // Backpressure: fill, refuse a third push, then drain in order
    drive(1'b1, 16'h0011, 32'h4, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_ready_after_1", in_ready, 1);
    drive(1'b1, 16'h0022, 32'h8, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_ready_after_2", in_ready, 0);
    chk("bp_head_a", out_data, 32'h11);
    drive(1'b1, 16'h0033, 32'hC, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_refused_head", out_data, 32'h11);
    chk("bp_still_full", in_ready, 0);
    drive(1'b0, 16'h0, 32'h0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_head_b", out_data, 32'h22);
    chk("bp_ready_after_pop", in_ready, 1);
    @(negedge clk);
    chk("bp_empty", out_valid, 0);
    out_ready = 1'b0;

    // Simultaneous push and pop with one entry
    drive(1'b1, 16'h0044, 32'h10, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h0055, 32'h14, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("pp_valid", out_valid, 1);
    chk("pp_head_c", out_data, 32'h55);
    chk("pp_count1", in_ready, 1);
    drive(1'b0, 16'h0, 32'h0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("pp_empty", out_valid, 0);
    out_ready = 1'b0;

    // Flush while full with a push attempt
    drive(1'b1, 16'h0066, 32'h18, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h0077, 32'h1C, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h0099, 32'h20, 3'd0, 1'b0, 1'b1);
    chk("fl_ready_preflush", in_ready, 0);
    @(negedge clk);
    drive(1'b0, 16'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_data", out_data, 0);
    @(negedge clk);
    chk("fl_push_absent", out_valid, 0);

    // Asynchronous reset mid-stream
    drive(1'b1, 16'h00AA, 32'h24, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #3 rstn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_ready", in_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b1, 16'h00BB, 32'h28, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("arst_first_push", out_valid, 1);
    chk("arst_first_data", out_data, 32'hBB);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Random traffic against the queue model
    q.delete();
    for (int i = 0; i < 2000; i++) begin
      if (q.size() > 0) begin
        chk("rnd_valid", out_valid, 1);
        chk("rnd_data", out_data, q[0].data);
        chk("rnd_pc4", out_pc4, q[0].pc4);
        chk("rnd_err", out_err, q[0].err);
      end else begin
        chk("rnd_valid", out_valid, 0);
        chk("rnd_data_idle", out_data, 0);
      end
      chk("rnd_in_ready", in_ready, (q.size() < 2) ? 1 : 0);
      drive(($urandom_range(0, 3) != 0), 16'($urandom), $urandom, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
      m_flush = flush;
      m_push  = in_valid && (q.size() < 2);
      m_pop   = out_ready && (q.size() > 0);
      exp_e   = ref_ext(in_imm, in_pc4, in_mode);
      @(negedge clk);
      if (m_flush) q.delete();
      else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(exp_e);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
